serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial two's-complement add/subtract, LSB first, producing the carry pair for the overflow detector.
// Optional sticky overflow output vs is enabled by defining SERIALADDER_STICKY_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cin,
  output logic             cout,
  output logic             v
`ifdef SERIALADDER_STICKY_EN
  ,
  output logic             vs
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [SW-1:0]    sr;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s;
  logic             cn;

  always_comb begin
    s  = sa[0] ^ sb[0] ^ c;
    cn = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // The partial sum lives in sr; visible outputs only change on the final bit so they hold the previous result during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      cin   <= 1'b0;
      cout  <= 1'b0;
      v     <= 1'b0;
`ifdef SERIALADDER_STICKY_EN
      vs    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b ^ {WIDTH{sub}};
            c     <= sub;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sr  <= SW'({s, sr} >> 1);
          c   <= cn;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= {s, sr};
            cin   <= c;
            cout  <= cn;
            v     <= c ^ cn;
`ifdef SERIALADDER_STICKY_EN
            if (c ^ cn) begin
              vs <= 1'b1;
            end
`endif
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: transaction-level arithmetic model, per-cycle compare, directed literal cases, random traffic.
// Honours SERIALADDER_STICKY_EN to also check the sticky overflow output.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cin;
  logic             cout;
  logic             v;
`ifdef SERIALADDER_STICKY_EN
  logic             vs;
`endif

  int nVectors = 0;
  int nFail    = 0;
  bit checkEn  = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cin   (cin),
    .cout  (cout),
    .v     (v)
`ifdef SERIALADDER_STICKY_EN
    ,
    .vs    (vs)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the signed/unsigned definitions, not from carry chains.
  function automatic void computeRef(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic s, output logic [WIDTH-1:0] r,
                                     output logic ci, output logic co, output logic ov);
    longint ux, uy, xs, ys, res;
    logic [63:0] t;
    ux  = longint'(x);
    uy  = longint'(y);
    xs  = x[WIDTH-1] ? ux - (longint'(1) << WIDTH) : ux;
    ys  = y[WIDTH-1] ? uy - (longint'(1) << WIDTH) : uy;
    res = s ? xs - ys : xs + ys;
    ov  = (res > (longint'(1) << (WIDTH-1)) - 1) || (res < -(longint'(1) << (WIDTH-1)));
    co  = s ? (ux >= uy) : (ux + uy >= (longint'(1) << WIDTH));
    t   = 64'(s ? ux - uy : ux + uy);
    r   = t[WIDTH-1:0];
    ci  = ov ^ co;
  endfunction

  int               phase = 0;
  logic [WIDTH-1:0] mSum = '0, pSum = '0;
  logic             mCin = 1'b0, mCout = 1'b0, mV = 1'b0, mVs = 1'b0;
  logic             pCin = 1'b0, pCout = 1'b0, pV = 1'b0;

  // phase counts cycles since the accepting edge; WIDTH+1 is the done cycle, 0 is idle.
  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      mSum  = '0;
      mCin  = 1'b0;
      mCout = 1'b0;
      mV    = 1'b0;
      mVs   = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        computeRef(a, b, sub, pSum, pCin, pCout, pV);
        phase = 1;
      end
    end else if (phase == WIDTH + 1) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == WIDTH + 1) begin
        mSum  = pSum;
        mCin  = pCin;
        mCout = pCout;
        mV    = pV;
        mVs   = mVs | pV;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", busy, phase != 0);
      checkOutput("done", done, phase == WIDTH + 1);
      checkOutput("sum",  sum,  mSum);
      checkOutput("cin",  cin,  mCin);
      checkOutput("cout", cout, mCout);
      checkOutput("v",    v,    mV);
`ifdef SERIALADDER_STICKY_EN
      checkOutput("vs",   vs,   mVs);
`endif
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < WIDTH + 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                       input logic [WIDTH-1:0] eSum, input logic eCin, input logic eCout, input logic eV);
    int lat;
    applyStimulus(x, y, s);
    waitDone(lat);
    checkOutput("lit_latency", lat, WIDTH);
    checkOutput("lit_sum",  sum,  eSum);
    checkOutput("lit_cin",  cin,  eCin);
    checkOutput("lit_cout", cout, eCout);
    checkOutput("lit_v",    v,    eV);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sum",  sum,  0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed arithmetic cases");
    runOp(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0);
    runOp(8'd100, 8'd28, 1'b0, 8'h80,  1'b1, 1'b0, 1'b1);
`ifdef SERIALADDER_STICKY_EN
    runOp(8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_vs_held", vs, 1);
`endif
    runOp(8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    runOp(8'd5,  8'd7,  1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    runOp(8'h80, 8'd1,  1'b1, 8'h7F, 1'b0, 1'b1, 1'b1);

    $display("[TB] start while busy");
    applyStimulus(8'd10, 8'd20, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(8'd99, 8'd1, 1'b0);
    waitDone(lat);
    checkOutput("busy_latency", lat, WIDTH - 3);
    checkOutput("busy_sum", sum, 8'd30);
    @(negedge clk);
    checkOutput("busy_no_second", busy, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(8'd50, 8'd60, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_sum",  sum,  0);
    checkOutput("abort_v",    v,    0);
    rst = 1'b0;
    runOp(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      sub   = 1'($urandom);
      rst   = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      start = 1'b1;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      sub   = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
